// File: rtl/tpg_pkg.sv
// tpg_pkg: shared colour constants, palette, mode codes and frame-start detect for the pattern generator
package tpg_pkg;
  localparam logic [2:0] TPG_BARS    = 3'd0;
  localparam logic [2:0] TPG_STRIPES = 3'd1;
  localparam logic [2:0] TPG_DIAG    = 3'd2;
  localparam logic [2:0] TPG_GRAD    = 3'd3;
  localparam logic [2:0] TPG_GREY    = 3'd4;
  localparam logic [2:0] TPG_CHECK   = 3'd5;
  localparam logic [23:0] C_BLACK    = 24'h000000;
  localparam logic [23:0] C_WHITE    = 24'hFFFFFF;
  localparam logic [23:0] C_BAR_MARK = 24'h00AA00;
  localparam logic [23:0] C_S_RED    = 24'hB00202;
  localparam logic [23:0] C_S_WHITE  = 24'hB0B0B0;
  localparam logic [23:0] C_S_BLUE   = 24'h0000F0;
  localparam logic [23:0] C_DIAG     = 24'h22AA22;
  localparam logic [23:0] C_MARK_32  = 24'h005555;
  localparam logic [23:0] C_MARK_1   = 24'h0000AA;
  function automatic logic [23:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    return 24'hFFFFFF;
      4'd1:    return 24'hFFFF00;
      4'd2:    return 24'h00FFFF;
      4'd3:    return 24'h00FF00;
      4'd4:    return 24'hFF00FF;
      4'd5:    return 24'hFF0000;
      4'd6:    return 24'h0000FF;
      4'd7:    return 24'h202020;
      4'd8:    return 24'h181818;
      4'd9:    return 24'h888800;
      4'd10:   return 24'h008888;
      4'd11:   return 24'h008800;
      4'd12:   return 24'h880088;
      4'd13:   return 24'h880000;
      4'd14:   return 24'h000088;
      default: return 24'h202020;
    endcase
  endfunction
  function automatic logic is_fs(input logic [10:0] h, input logic [9:0] v);
    return h == 11'd1 && v == 10'd1;
  endfunction
endpackage

// File: rtl/tpg_breath_ctrl.sv
// tpg_breath_ctrl: frame-rate triangle brightness level, 0..255..0, stepped every 2^BREATH_DIV_LOG2 frame starts
module tpg_breath_ctrl #(
  parameter int BREATH_DIV_LOG2 = 4
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       fs,
  output logic [7:0] level
);
  localparam int DW = BREATH_DIV_LOG2 > 0 ? BREATH_DIV_LOG2 : 1;
  logic [DW-1:0] div_q, div_d;
  logic [7:0] level_q, level_d;
  logic dir_q, dir_d, dir_n, wrap;
  // divider wrap steps the level; direction turns at the ends before the step so it never overflows
  always_comb begin
    wrap    = fs && (BREATH_DIV_LOG2 == 0 || div_q == '1);
    div_d   = fs ? div_q + 1'b1 : div_q;
    dir_n   = level_q == 8'hFF ? 1'b0 : level_q == 8'h00 ? 1'b1 : dir_q;
    dir_d   = wrap ? dir_n : dir_q;
    level_d = wrap ? (dir_n ? level_q + 8'd1 : level_q - 8'd1) : level_q;
  end
  // breath state registers
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      div_q   <= '0;
      level_q <= '0;
      dir_q   <= 1'b1;
    end else begin
      div_q   <= div_d;
      level_q <= level_d;
      dir_q   <= dir_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/pattern_gen_frame.sv
// pattern_gen_frame: two-stage, frame-synchronous VGA test pattern generator with six patterns
module pattern_gen_frame
  import tpg_pkg::*;
#(
  parameter int VIDEO_W         = 640,
  parameter int VIDEO_H         = 480,
  parameter int IMG_W           = 256,
  parameter int IMG_H           = 64,
  parameter int BAR_COUNT       = 16,
  parameter int BREATH_DIV_LOG2 = 4,
  parameter int CHECK_LOG2      = 5
) (
  input  logic        PCLK,
  input  logic        RESET,
  input  logic [2:0]  TP_SEL,
  input  logic [10:0] ADDR_H,
  input  logic [9:0]  ADDR_V,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic [7:0]  BREATH_LEVEL,
  output logic        FRAME_TICK
);
  logic fs, sync_q, sync_d;
  logic [2:0] mode_q, mode_d;
  logic [9:0] scroll_q, scroll_d;
  logic [10:0] h1_q, h1_d;
  logic [9:0] v1_q, v1_d;
  logic act1_q, act1_d, win1_q, win1_d, fs1_q, fs1_d;
  logic m10_q, m10_d, m32_q, m32_d, m11_q, m11_d;
  logic [3:0] bar1_q, bar1_d;
  logic [23:0] rgb_q, rgb_d, stripe, c;
  logic tick_q;
  logic [7:0] level, g, gv;
  logic [10:0] ds, dm;
  logic lit, chk;
  tpg_breath_ctrl #(.BREATH_DIV_LOG2(BREATH_DIV_LOG2)) u_breath (
    .PCLK  (PCLK),
    .RESET (RESET),
    .fs    (fs),
    .level (level)
  );
  // stage 1 next state plus frame state; sync gates output until the first frame start after reset
  always_comb begin
    fs       = is_fs(ADDR_H, ADDR_V);
    sync_d   = sync_q | fs;
    mode_d   = fs ? TP_SEL : mode_q;
    scroll_d = fs ? (scroll_q == 10'(VIDEO_H - 1) ? 10'd0 : scroll_q + 10'd1) : scroll_q;
    h1_d     = ADDR_H;
    v1_d     = ADDR_V;
    act1_d   = ADDR_H != 11'd0 && ADDR_H <= 11'(VIDEO_W) && ADDR_V != 10'd0 && ADDR_V <= 10'(VIDEO_H) && sync_d;
    win1_d   = ADDR_H != 11'd0 && ADDR_H <= 11'(IMG_W) && ADDR_V != 10'd0 && ADDR_V <= 10'(IMG_H);
    bar1_d   = 4'(((16'(ADDR_H) - 16'd1) * 16'(BAR_COUNT)) / 16'(VIDEO_W));
    m10_d    = ADDR_H == 11'd10 && ADDR_V == 10'd10;
    m32_d    = ADDR_H == 11'd32 && ADDR_V == 10'd32;
    m11_d    = fs;
    fs1_d    = fs;
  end
  // stage 2 colour: pattern select, blanking forced to black
  always_comb begin
    stripe = v1_q <= 10'(VIDEO_H / 6) ? C_S_RED :
             v1_q <= 10'(2 * VIDEO_H / 6) ? C_S_WHITE :
             v1_q <= 10'(4 * VIDEO_H / 6) ? C_S_BLUE :
             v1_q <= 10'(5 * VIDEO_H / 6) ? C_S_WHITE : C_S_RED;
    ds     = {1'b0, h1_q[10:1]} + {1'b0, scroll_q};
    dm     = ds >= 11'(VIDEO_H) ? ds - 11'(VIDEO_H) : ds;
    lit    = dm == ({1'b0, v1_q} - 11'd1);
    g      = 8'((14'(h1_q[7:0]) * 14'(v1_q[5:0])) >> 6);
    gv     = 8'((16'(g) * 16'(level)) >> 8);
    chk    = 1'(((h1_q - 11'd1) >> CHECK_LOG2) ^ (({1'b0, v1_q} - 11'd1) >> CHECK_LOG2)) ^ level[7];
    c      = mode_q == TPG_BARS    ? (m10_q ? C_BAR_MARK : palette(bar1_q)) :
             mode_q == TPG_STRIPES ? stripe :
             mode_q == TPG_DIAG    ? (lit ? C_DIAG : C_BLACK) :
             mode_q == TPG_GRAD    ? (!win1_q ? C_BLACK : m32_q ? C_MARK_32 : m11_q ? C_MARK_1 : {gv, gv, gv}) :
             mode_q == TPG_GREY    ? {level, level, level} :
             mode_q == TPG_CHECK   ? (chk ? C_WHITE : C_BLACK) : C_BLACK;
    rgb_d  = act1_q ? c : C_BLACK;
  end
  // pipeline and frame registers; reset marks both stages blank
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      sync_q   <= 1'b0;
      mode_q   <= TPG_BARS;
      scroll_q <= '0;
      h1_q     <= '0;
      v1_q     <= '0;
      act1_q   <= 1'b0;
      win1_q   <= 1'b0;
      bar1_q   <= '0;
      m10_q    <= 1'b0;
      m32_q    <= 1'b0;
      m11_q    <= 1'b0;
      fs1_q    <= 1'b0;
      rgb_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      mode_q   <= mode_d;
      scroll_q <= scroll_d;
      h1_q     <= h1_d;
      v1_q     <= v1_d;
      act1_q   <= act1_d;
      win1_q   <= win1_d;
      bar1_q   <= bar1_d;
      m10_q    <= m10_d;
      m32_q    <= m32_d;
      m11_q    <= m11_d;
      fs1_q    <= fs1_d;
      rgb_q    <= rgb_d;
      tick_q   <= fs1_q;
    end
  end
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign FRAME_TICK   = tick_q;
  assign BREATH_LEVEL = level;
endmodule

// File: tb/tb_pattern_gen_frame.sv
// tb_pattern_gen_frame: table vectors plus scoreboard-checked sequences for the frame-synchronous pattern generator
module tb_pattern_gen_frame;
  logic        PCLK = 1'b0;
  logic        RESET = 1'b0;
  logic [2:0]  TP_SEL = 3'd0;
  logic [10:0] ADDR_H = '0;
  logic [9:0]  ADDR_V = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B, BREATH_LEVEL;
  logic        FRAME_TICK;

  always #5 PCLK = ~PCLK;

  pattern_gen_frame #(.BREATH_DIV_LOG2(0)) dut (
    .PCLK         (PCLK),
    .RESET        (RESET),
    .TP_SEL       (TP_SEL),
    .ADDR_H       (ADDR_H),
    .ADDR_V       (ADDR_V),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .BREATH_LEVEL (BREATH_LEVEL),
    .FRAME_TICK   (FRAME_TICK)
  );

  typedef struct {logic chk; logic [23:0] rgb; logic tick; string nm;} exp_t;
  typedef struct {int h; int v; logic [23:0] rgb; string nm;} vec_t;
  exp_t sbq[$];
  vec_t tbl[11];
  logic [23:0] pal [16];
  int n_cmp = 0, n_bad = 0;
  int m_mode, m_level, m_dir, m_scroll, m_sync;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_level = 0; m_dir = 1; m_scroll = 0; m_sync = 0;
  endtask

  task automatic model_fs(input int sel);
    m_sync = 1;
    m_mode = sel;
    if (m_level == 255) m_dir = 0;
    else if (m_level == 0) m_dir = 1;
    m_level = m_dir ? m_level + 1 : m_level - 1;
    m_scroll = (m_scroll + 1) % 480;
  endtask

  function automatic logic [23:0] model_px(input int h, input int v);
    int g;
    logic [7:0] lv;
    logic [23:0] c;
    lv = 8'(m_level);
    if (m_sync == 0 || h < 1 || h > 640 || v < 1 || v > 480) return 24'h0;
    case (m_mode)
      0: c = (h == 10 && v == 10) ? 24'h00AA00 : pal[(h - 1) * 16 / 640];
      1: c = (v <= 80 || v > 400) ? 24'hB00202 : (v <= 160 || v > 320) ? 24'hB0B0B0 : 24'h0000F0;
      2: c = ((v - 1) == ((h >> 1) + m_scroll) % 480) ? 24'h22AA22 : 24'h0;
      3: begin
        if (h > 256 || v > 64) c = 24'h0;
        else if (h == 32 && v == 32) c = 24'h005555;
        else if (h == 1 && v == 1) c = 24'h0000AA;
        else begin
          g = ((h % 256) * (v % 64)) >> 6;
          g = (g * m_level) >> 8;
          c = {g[7:0], g[7:0], g[7:0]};
        end
      end
      4: c = {lv, lv, lv};
      5: c = (((((h - 1) >> 5) ^ ((v - 1) >> 5)) & 1) ^ int'(lv[7])) != 0 ? 24'hFFFFFF : 24'h0;
      default: c = 24'h0;
    endcase
    return c;
  endfunction

  task automatic drive(input int h, input int v, input int sel, input logic chk,
                       input logic ovr, input logic [23:0] ov, input string nm);
    exp_t e;
    ADDR_H = 11'(h);
    ADDR_V = 10'(v);
    TP_SEL = 3'(sel);
    if (h == 1 && v == 1) model_fs(sel);
    e.chk  = chk;
    e.rgb  = ovr ? ov : model_px(h, v);
    e.tick = (h == 1 && v == 1);
    e.nm   = nm;
    sbq.push_back(e);
    @(posedge PCLK);
    #1;
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      if (e.chk) begin
        check(e.nm, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, e.rgb});
        check({e.nm, "_tick"}, {31'h0, FRAME_TICK}, {31'h0, e.tick});
      end
    end
  endtask

  task automatic flush();
    repeat (2) drive(0, 0, 0, 1'b0, 1'b0, 24'h0, "flush");
  endtask

  task automatic reset_dut(input string nm);
    @(negedge PCLK);
    RESET = 1'b1;
    #1;
    check({nm, "_rgb"}, {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check({nm, "_tick"}, {31'h0, FRAME_TICK}, 32'h0);
    check({nm, "_level"}, {24'h0, BREATH_LEVEL}, 32'h0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    RESET = 1'b0;
    sbq.delete();
    model_reset();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pal = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h202020,
            24'h181818, 24'h888800, 24'h008888, 24'h008800, 24'h880088, 24'h880000, 24'h000088, 24'h202020};
    tbl = '{'{41, 1, 24'hFFFF00, "bars_41"},     '{0, 1, 24'h000000, "bars_0"},
            '{641, 1, 24'h000000, "bars_641"},   '{640, 1, 24'h202020, "bars_640"},
            '{321, 1, 24'h181818, "bars_321"},   '{10, 10, 24'h00AA00, "bars_mark"},
            '{11, 10, 24'hFFFFFF, "bars_11_10"}, '{600, 5, 24'h000088, "bars_600"},
            '{1, 480, 24'hFFFFFF, "bars_1_480"}, '{1, 481, 24'h000000, "bars_1_481"},
            '{281, 7, 24'h202020, "bars_281"}};
    model_reset();
    reset_dut("rst0");
    drive(1, 1, 0, 1'b1, 1'b1, 24'hFFFFFF, "bars_1");
    for (int i = 0; i < 11; i++) drive(tbl[i].h, tbl[i].v, 0, 1'b1, 1'b1, tbl[i].rgb, tbl[i].nm);
    drive(100, 200, 4, 1'b1, 1'b1, 24'h00FFFF, "sel_mid_bars");
    drive(500, 200, 4, 1'b1, 1'b0, 24'h0, "sel_mid_model");
    drive(1, 1, 4, 1'b1, 1'b1, 24'h020202, "sel_fs_grey");
    drive(100, 200, 4, 1'b1, 1'b1, 24'h020202, "grey_px");
    flush();
    reset_dut("rst1");
    for (int i = 0; i < 255; i++) drive(1, 1, 4, 1'b1, 1'b0, 24'h0, "breath_fs");
    check("level_255", {24'h0, BREATH_LEVEL}, 32'd255);
    drive(1, 1, 4, 1'b1, 1'b1, 24'hFEFEFE, "breath_turn");
    check("level_256", {24'h0, BREATH_LEVEL}, 32'd254);
    for (int i = 0; i < 44; i++) drive(1, 1, 4, 1'b1, 1'b0, 24'h0, "breath_fs_dn");
    check("level_300", {24'h0, BREATH_LEVEL}, 32'd210);
    drive(200, 300, 5, 1'b1, 1'b0, 24'h0, "check_phase");
    flush();
    reset_dut("rst2");
    for (int i = 0; i < 128; i++) drive(1, 1, 3, 1'b1, 1'b1, 24'h0000AA, "grad_fs");
    check("level_128", {24'h0, BREATH_LEVEL}, 32'd128);
    drive(255, 63, 3, 1'b1, 1'b1, 24'h7D7D7D, "grad_255_63");
    drive(32, 32, 3, 1'b1, 1'b1, 24'h005555, "grad_mark");
    drive(257, 10, 3, 1'b1, 1'b1, 24'h000000, "grad_outside");
    drive(100, 40, 3, 1'b1, 1'b1, 24'h1F1F1F, "grad_mid");
    flush();
    reset_dut("rst3");
    for (int i = 0; i < 479; i++) drive(1, 1, 2, 1'b1, 1'b0, 24'h0, "diag_fs");
    drive(2, 1, 2, 1'b1, 1'b1, 24'h22AA22, "diag_2_1");
    drive(2, 2, 2, 1'b1, 1'b1, 24'h000000, "diag_2_2");
    drive(1, 1, 2, 1'b1, 1'b1, 24'h22AA22, "diag_wrap");
    drive(41, 21, 2, 1'b1, 1'b0, 24'h0, "diag_model");
    flush();
    reset_dut("rst4");
    drive(1, 1, 1, 1'b1, 1'b1, 24'hB00202, "stripe_fs");
    drive(5, 100, 1, 1'b1, 1'b1, 24'hB0B0B0, "stripe_white");
    drive(5, 200, 1, 1'b1, 1'b1, 24'h0000F0, "stripe_blue");
    drive(5, 450, 1, 1'b1, 1'b1, 24'hB00202, "stripe_red");
    reset_dut("rst_mid");
    drive(6, 100, 0, 1'b1, 1'b1, 24'h000000, "post_rst_blank0");
    drive(7, 100, 0, 1'b1, 1'b1, 24'h000000, "post_rst_blank1");
    drive(8, 300, 0, 1'b1, 1'b1, 24'h000000, "post_rst_blank2");
    drive(1, 1, 0, 1'b1, 1'b1, 24'hFFFFFF, "post_rst_fs");
    drive(41, 1, 0, 1'b1, 1'b1, 24'hFFFF00, "post_rst_bars");
    flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
